fsrcnn_tile_scheduler: RTL

Top-level sequencer for one convolution layer of the FSRCNN accelerator. It drives the 3-bit `top_level_state` bus that the loaders, PE array and write-back unit decode, and walks the output-tile, input-tile and kernel-position loops. It also clears the weight loader before every weight tile and issues compute and write-back handshakes. It sits between the host/AXI-Lite configuration and all datapath blocks.

---
 rtl/fsrcnn_pkg.sv | 13 +
 rtl/loop_nest_cnt.sv | 43 ++++
 rtl/fsrcnn_tile_scheduler.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fsrcnn_pkg.sv
// fsrcnn_pkg: state encodings and tile defaults shared by the scheduler, loaders and PE array
package fsrcnn_pkg;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LDIN = 3'd1,
    ST_LDW  = 3'd2,
    ST_COMP = 3'd3,
    ST_WB   = 3'd4
  } top_state_t;
  typedef enum logic [2:0] {S_IDLE, S_IN_LOAD, S_WL_CLR, S_WL_LOAD, S_COMP, S_WB, S_FIN} sched_state_t;
  localparam int DEF_TM = 16;
  localparam int DEF_TN = 16;
endpackage

// File: rtl/loop_nest_cnt.sv
// loop_nest_cnt: cascaded kernel/input-tile counters plus the output-tile counter stepped on write-back
module loop_nest_cnt #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_step,
  input  logic          i_oc_step,
  input  logic [CW-1:0] i_kk,
  input  logic [CW-1:0] i_n_tiles,
  input  logic [CW-1:0] i_m_tiles,
  output logic [CW-1:0] o_kc,
  output logic [CW-1:0] o_ic,
  output logic [CW-1:0] o_oc,
  output logic          o_kc_last,
  output logic          o_ic_last,
  output logic          o_oc_last
);
  logic [CW-1:0] r_kc, r_ic, r_oc;
  assign o_kc = r_kc;
  assign o_ic = r_ic;
  assign o_oc = r_oc;
  assign o_kc_last = r_kc == i_kk - CW'(1);
  assign o_ic_last = r_ic == i_n_tiles - CW'(1);
  assign o_oc_last = r_oc == i_m_tiles - CW'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_kc <= '0;
      r_ic <= '0;
      r_oc <= '0;
    end else if (i_clr) begin
      r_kc <= '0;
      r_ic <= '0;
      r_oc <= '0;
    end else begin
      if (i_step) begin
        r_kc <= o_kc_last ? '0 : r_kc + CW'(1);
        if (o_kc_last) r_ic <= o_ic_last ? '0 : r_ic + CW'(1);
      end
      if (i_oc_step && !o_oc_last) r_oc <= r_oc + CW'(1);
    end
endmodule

// File: rtl/fsrcnn_tile_scheduler.sv
// fsrcnn_tile_scheduler: layer sequencer walking output/input tiles and kernel positions,
// driving top_level_state and the weight-loader clear, compute and done handshakes.
module fsrcnn_tile_scheduler import fsrcnn_pkg::*; #(
  parameter int CW = 8,
  parameter int TN = DEF_TN
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] cfg_m_tiles,
  input  logic [CW-1:0] cfg_n_tiles,
  input  logic [CW-1:0] cfg_kk,
  input  logic          il_finish,
  input  logic          w_tvalid,
  input  logic          wl_finish_flg,
  input  logic          pe_done,
  input  logic          wb_finish,
  output logic [2:0]    top_level_state,
  output logic          wl_rst,
  output logic          pe_start,
  output logic          acc_clear,
  output logic [CW-1:0] oc_idx,
  output logic [CW-1:0] ic_idx,
  output logic [CW-1:0] kc_idx,
  output logic          busy,
  output logic          done
);
  localparam int BW = $clog2(TN + 1);
  sched_state_t  r_state;
  top_state_t    r_tls;
  logic          r_wl_rst, r_pe_start, r_acc_clear, r_busy, r_done;
  logic [CW-1:0] r_m, r_n, r_kk;
  logic [BW-1:0] r_beats;
  logic          w_clr, w_step, w_oc_step, w_zero, w_kc_last, w_ic_last, w_oc_last;
  assign w_clr     = r_state == S_IDLE && start;
  assign w_step    = r_state == S_COMP && pe_done;
  assign w_oc_step = r_state == S_WB && wb_finish;
  assign w_zero    = cfg_m_tiles == '0 || cfg_n_tiles == '0 || cfg_kk == '0;
  assign top_level_state = r_tls;
  assign wl_rst    = r_wl_rst;
  assign pe_start  = r_pe_start;
  assign acc_clear = r_acc_clear;
  assign busy      = r_busy;
  assign done      = r_done;
  loop_nest_cnt #(.CW(CW)) u_cnt (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_step(w_step), .i_oc_step(w_oc_step),
    .i_kk(r_kk), .i_n_tiles(r_n), .i_m_tiles(r_m),
    .o_kc(kc_idx), .o_ic(ic_idx), .o_oc(oc_idx),
    .o_kc_last(w_kc_last), .o_ic_last(w_ic_last), .o_oc_last(w_oc_last)
  );
  // Outputs are set from the next state so every output is a flop with no input-to-output path
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state     <= S_IDLE;
      r_tls       <= ST_IDLE;
      r_wl_rst    <= 1'b1;
      r_pe_start  <= 1'b0;
      r_acc_clear <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_m         <= '0;
      r_n         <= '0;
      r_kk        <= '0;
      r_beats     <= '0;
    end else begin
      r_wl_rst    <= 1'b0;
      r_pe_start  <= 1'b0;
      r_acc_clear <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_m    <= cfg_m_tiles;
          r_n    <= cfg_n_tiles;
          r_kk   <= cfg_kk;
          r_busy <= 1'b1;
          if (w_zero) begin
            r_state <= S_FIN;
            r_tls   <= ST_IDLE;
          end else begin
            r_state <= S_IN_LOAD;
            r_tls   <= ST_LDIN;
          end
        end
        S_IN_LOAD: if (il_finish) begin
          r_state  <= S_WL_CLR;
          r_tls    <= ST_IDLE;
          r_wl_rst <= 1'b1;
        end
        S_WL_CLR: begin
          r_state <= S_WL_LOAD;
          r_tls   <= ST_LDW;
          r_beats <= '0;
        end
        S_WL_LOAD: if (wl_finish_flg && w_tvalid) begin
          r_state     <= S_COMP;
          r_tls       <= ST_COMP;
          r_pe_start  <= 1'b1;
          r_acc_clear <= kc_idx == '0 && ic_idx == '0;
        end else if (w_tvalid) r_beats <= r_beats + BW'(1);
        S_COMP: if (pe_done) begin
          if (!w_kc_last) begin
            r_state  <= S_WL_CLR;
            r_tls    <= ST_IDLE;
            r_wl_rst <= 1'b1;
          end else if (!w_ic_last) begin
            r_state <= S_IN_LOAD;
            r_tls   <= ST_LDIN;
          end else begin
            r_state <= S_WB;
            r_tls   <= ST_WB;
          end
        end
        S_WB: if (wb_finish) begin
          if (w_oc_last) begin
            r_state <= S_FIN;
            r_tls   <= ST_IDLE;
          end else begin
            r_state <= S_IN_LOAD;
            r_tls   <= ST_LDIN;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_tls   <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  // The loader flags its last column on the TN-th accepted beat of a weight tile
  a_exit_beat: assert property (@(posedge clk) disable iff (rst)
    (r_state == S_WL_LOAD && wl_finish_flg && w_tvalid) |-> r_beats == BW'(TN - 1));
endmodule
